// File: rtl/hyperbus_read_capture_pkg.sv
// hyperbus_pkg: shared types for the HyperBus RWDS-domain read capture path.
// Holds the capture FSM state encoding, the skid word layout and the skid depth.
// Imported by hyperbus_read_skid, hyperbus_read_capture and the capture interface.
package hyperbus_pkg;

   typedef enum logic [1:0] {
      CAP_SKIP   = 2'd0,
      CAP_STREAM = 2'd1,
      CAP_DONE   = 2'd2
   } hyper_cap_state_e;

   typedef struct packed {
      logic        last;
      logic [15:0] data;
   } hyper_rd_word_t;

   localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/hyperbus_read_capture_if.sv
// hyperbus_read_capture_if: bus between the DDR input cells / CDC FIFO side and the capture stage.
// Ports: data_i, burst_len_i, ready_i toward the capture stage; valid_o, data_o, last_o,
//        overrun_o, done_o (and words_o when HYPERBUS_READ_CAPTURE_STATS_EN is defined) back out.
// Modports: master = environment (DDR cells + FIFO source), slave = capture stage.
interface hyperbus_read_capture_if #(
   parameter int LEN_W = 8
);
   logic [15:0]      data_i;
   logic [LEN_W-1:0] burst_len_i;
   logic             ready_i;
   logic             valid_o;
   logic [15:0]      data_o;
   logic             last_o;
   logic             overrun_o;
   logic             done_o;
`ifdef HYPERBUS_READ_CAPTURE_STATS_EN
   logic [LEN_W-1:0] words_o;

   modport master (
      output data_i, burst_len_i, ready_i,
      input  valid_o, data_o, last_o, overrun_o, done_o, words_o
   );

   modport slave (
      input  data_i, burst_len_i, ready_i,
      output valid_o, data_o, last_o, overrun_o, done_o, words_o
   );
`else
   modport master (
      output data_i, burst_len_i, ready_i,
      input  valid_o, data_o, last_o, overrun_o, done_o
   );

   modport slave (
      input  data_i, burst_len_i, ready_i,
      output valid_o, data_o, last_o, overrun_o, done_o
   );
`endif
endinterface

// File: rtl/hyperbus_read_capture_skid.sv
// hyperbus_read_skid: 2-entry skid buffer of hyper_rd_word_t with a registered head word.
// Ports: clk_rwds, resetReadModule, push_i/word_i in, pop_i in, head_o/valid_o out,
//        overrun_o (sticky drop flag), accept_o (only with HYPERBUS_READ_CAPTURE_STATS_EN).
// Push and pop on the same edge is always accepted, even when full; push into a full buffer
// without a pop drops the word and sets overrun_o until reset.
module hyperbus_read_skid
   import hyperbus_pkg::*;
(
   input  logic           clk_rwds,
   input  logic           resetReadModule,
   input  logic           push_i,
   input  hyper_rd_word_t word_i,
   input  logic           pop_i,
   output hyper_rd_word_t head_o,
   output logic           valid_o,
`ifdef HYPERBUS_READ_CAPTURE_STATS_EN
   output logic           accept_o,
`endif
   output logic           overrun_o
);

   hyper_rd_word_t head_q;
   hyper_rd_word_t tail_q;
   logic [1:0]     count_q;
   logic           overrun_q;

   logic full;
   logic empty;
   logic pop_ok;
   logic accept;

   assign full   = (count_q == 2'(SKID_DEPTH));
   assign empty  = (count_q == 2'd0);
   // A pop request on an empty buffer is meaningless and ignored.
   assign pop_ok = pop_i && !empty;
   // The pop frees a slot on the same edge, so a full buffer still takes the push.
   assign accept = push_i && (!full || pop_ok);

   always_ff @(posedge clk_rwds or posedge resetReadModule) begin
      if (resetReadModule) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= 2'd0;
         overrun_q <= 1'b0;
      end else begin
         if (push_i && !accept) begin
            overrun_q <= 1'b1;
         end
         case ({accept, pop_ok})
            2'b10: begin
               if (empty) head_q <= word_i;
               else       tail_q <= word_i;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               // Head stays stale when going empty; valid_o masks it.
               if (full) head_q <= tail_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (full) begin
                  head_q <= tail_q;
                  tail_q <= word_i;
               end else begin
                  head_q <= word_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_o    = head_q;
   assign valid_o   = !empty;
   assign overrun_o = overrun_q;
`ifdef HYPERBUS_READ_CAPTURE_STATS_EN
   assign accept_o  = accept;
`endif

endmodule

// File: rtl/hyperbus_read_capture.sv
// hyperbus_read_capture: RWDS-domain read stage; skips DDR fill beats, counts burst words,
// tags the final word and feeds the CDC FIFO source through a 2-entry skid.
// Ports: clk_rwds, resetReadModule (async, active-high, held between bursts), bus (slave modport).
// Optional: HYPERBUS_READ_CAPTURE_STATS_EN adds bus.words_o, the count of accepted pushes.
module hyperbus_read_capture
   import hyperbus_pkg::*;
#(
   parameter int LEN_W      = 8,
   parameter int SKIP_BEATS = 1
) (
   input  logic                  clk_rwds,
   input  logic                  resetReadModule,
   hyperbus_read_capture_if.slave bus
);

   localparam logic [1:0]       SKIP_LAST = (SKIP_BEATS > 0) ? 2'(SKIP_BEATS - 1) : 2'd0;
   // With no fill beats the first edge already carries burst data.
   localparam hyper_cap_state_e RESET_STATE =
      hyper_cap_state_e'((SKIP_BEATS == 0) ? CAP_STREAM : CAP_SKIP);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   hyper_cap_state_e state_q, state_d;
   logic [1:0]       skip_cnt_q, skip_cnt_d;
   logic [LEN_W-1:0] word_cnt_q;

   logic             len_zero;
   logic             is_last;
   logic             push;
   logic             pop;
   hyper_rd_word_t   push_word;
   hyper_rd_word_t   head;
   logic             skid_valid;
   logic             skid_overrun;

   assign len_zero = (bus.burst_len_i == '0);
   assign is_last  = (word_cnt_q == (bus.burst_len_i - LEN_ONE));

   always_ff @(posedge clk_rwds or posedge resetReadModule) begin
      if (resetReadModule) begin
         state_q    <= RESET_STATE;
         skip_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         skip_cnt_q <= skip_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      skip_cnt_d = skip_cnt_q;
      push       = 1'b0;
      case (state_q)
         CAP_SKIP: begin
            if (len_zero) begin
               state_d = CAP_DONE;
            end else begin
               skip_cnt_d = skip_cnt_q + 2'd1;
               if (skip_cnt_q == SKIP_LAST) state_d = CAP_STREAM;
            end
         end
         CAP_STREAM: begin
            // Only reachable with an empty burst when there are no fill beats.
            if (len_zero) begin
               state_d = CAP_DONE;
            end else begin
               push = 1'b1;
               if (is_last) state_d = CAP_DONE;
            end
         end
         default: ;
      endcase
   end

   // Counts every push, including drops, so done_o still fires after an overrun.
   always_ff @(posedge clk_rwds or posedge resetReadModule) begin
      if (resetReadModule) begin
         word_cnt_q <= '0;
      end else if (push && (word_cnt_q != '1)) begin
         word_cnt_q <= word_cnt_q + LEN_ONE;
      end
   end

   assign push_word.last = is_last;
   assign push_word.data = bus.data_i;
   assign pop            = skid_valid && bus.ready_i;

`ifdef HYPERBUS_READ_CAPTURE_STATS_EN
   logic             skid_accept;
   logic [LEN_W-1:0] words_q;

   hyperbus_read_skid u_skid (
      .clk_rwds        (clk_rwds),
      .resetReadModule (resetReadModule),
      .push_i          (push),
      .word_i          (push_word),
      .pop_i           (pop),
      .head_o          (head),
      .valid_o         (skid_valid),
      .accept_o        (skid_accept),
      .overrun_o       (skid_overrun)
   );

   always_ff @(posedge clk_rwds or posedge resetReadModule) begin
      if (resetReadModule) begin
         words_q <= '0;
      end else if (skid_accept && (words_q != '1)) begin
         words_q <= words_q + LEN_ONE;
      end
   end

   assign bus.words_o = words_q;
`else
   hyperbus_read_skid u_skid (
      .clk_rwds        (clk_rwds),
      .resetReadModule (resetReadModule),
      .push_i          (push),
      .word_i          (push_word),
      .pop_i           (pop),
      .head_o          (head),
      .valid_o         (skid_valid),
      .overrun_o       (skid_overrun)
   );
`endif

   assign bus.valid_o   = skid_valid;
   assign bus.data_o    = head.data;
   assign bus.last_o    = head.last;
   assign bus.overrun_o = skid_overrun;
   assign bus.done_o    = (state_q == CAP_DONE);

endmodule

// File: tb/tb_hyperbus_read_capture.sv
// tb_hyperbus_read_capture: self-checking bench for hyperbus_read_capture.
// Ports: none; drives the capture interface and a gated clk_rwds, compares against a queue model.
// Optional: HYPERBUS_READ_CAPTURE_STATS_EN also checks words_o.
module tb_hyperbus_read_capture;
   import hyperbus_pkg::*;

   localparam int LEN_W = 8;
   localparam int SKIP  = 1;

   logic clk_rwds        = 1'b0;
   logic resetReadModule = 1'b1;

   hyperbus_read_capture_if #(.LEN_W(LEN_W)) bus ();

   hyperbus_read_capture #(.LEN_W(LEN_W), .SKIP_BEATS(SKIP)) dut (
      .clk_rwds        (clk_rwds),
      .resetReadModule (resetReadModule),
      .bus             (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: the skid is a bounded queue of {last, data}; a burst is described by
   // how many edges have passed, how many words were presented and how many were kept.
   logic [16:0] m_q[$];
   logic [16:0] got[$];
   int          m_edges;
   int          m_words;
   int          m_acc;
   int          blen;
   bit          m_ovr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit exp_done();
      if (blen == 0) return (m_edges >= 1);
      return (m_words >= blen);
   endfunction

   task automatic model_step(input logic [15:0] d, input logic r);
      if (m_q.size() > 0 && r) void'(m_q.pop_front());
      if (blen != 0 && m_edges >= SKIP && m_words < blen) begin
         if (m_q.size() < SKID_DEPTH) begin
            m_q.push_back({(m_words == blen - 1), d});
            m_acc++;
         end else begin
            m_ovr = 1'b1;
         end
         m_words++;
      end
      m_edges++;
   endtask

   task automatic compare_outputs();
      check("valid", 32'(bus.valid_o), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("data", 32'(bus.data_o), 32'(m_q[0][15:0]));
         check("last", 32'(bus.last_o), 32'(m_q[0][16]));
      end
      check("overrun", 32'(bus.overrun_o), 32'(m_ovr));
      check("done", 32'(bus.done_o), 32'(exp_done()));
`ifdef HYPERBUS_READ_CAPTURE_STATS_EN
      check("words", 32'(bus.words_o), 32'(m_acc));
`endif
   endtask

   // Called with clk_rwds low; asserts reset asynchronously and checks the cleared outputs.
   task automatic do_reset(input int len);
      #1 resetReadModule = 1'b1;
      bus.burst_len_i = LEN_W'(len);
      #1;
      check("rst_valid", 32'(bus.valid_o), 32'd0);
      check("rst_data", 32'(bus.data_o), 32'd0);
      check("rst_last", 32'(bus.last_o), 32'd0);
      check("rst_overrun", 32'(bus.overrun_o), 32'd0);
      check("rst_done", 32'(bus.done_o), 32'd0);
`ifdef HYPERBUS_READ_CAPTURE_STATS_EN
      check("rst_words", 32'(bus.words_o), 32'd0);
`endif
      m_q.delete();
      got.delete();
      m_edges = 0;
      m_words = 0;
      m_acc   = 0;
      m_ovr   = 1'b0;
      blen    = len;
      #1 resetReadModule = 1'b0;
   endtask

   task automatic edge_cyc(input logic [15:0] d, input logic r);
      bus.data_i  = d;
      bus.ready_i = r;
      if (bus.valid_o && r) got.push_back({bus.last_o, bus.data_o});
      model_step(d, r);
      #5 clk_rwds = 1'b1;
      #4 compare_outputs();
      #1 clk_rwds = 1'b0;
   endtask

   task automatic check_got(input string tag, input logic [16:0] exp[$]);
      check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         check({tag, "_word"}, 32'(got[i]), 32'(exp[i]));
      end
   endtask

   initial begin
      logic [16:0] e[$];
      int          n;
      int          rdy_pct;

      bus.data_i      = 16'h0;
      bus.ready_i     = 1'b0;
      bus.burst_len_i = '0;

      // 1: clean burst of four with the FIFO always ready.
      do_reset(4);
      edge_cyc(16'hDEAD, 1'b1);
      for (int i = 1; i <= 4; i++) edge_cyc(16'hA000 + 16'(i), 1'b1);
      for (int i = 0; i < 2; i++) edge_cyc(16'h0000, 1'b1);
      e.delete();
      e.push_back(17'h0A001); e.push_back(17'h0A002); e.push_back(17'h0A003); e.push_back(17'h1A004);
      check_got("t1", e);
      check("t1_overrun", 32'(bus.overrun_o), 32'd0);
      check("t1_done", 32'(bus.done_o), 32'd1);
`ifdef HYPERBUS_READ_CAPTURE_STATS_EN
      check("t1_words", 32'(bus.words_o), 32'd4);
`endif

      // 2: FIFO stalls long enough for the third word to be lost.
      do_reset(4);
      edge_cyc(16'hDEAD, 1'b1);
      edge_cyc(16'hA001, 1'b0);
      edge_cyc(16'hA002, 1'b0);
      edge_cyc(16'hA003, 1'b0);
      edge_cyc(16'hA004, 1'b1);
      for (int i = 0; i < 3; i++) edge_cyc(16'h0000, 1'b1);
      e.delete();
      e.push_back(17'h0A001); e.push_back(17'h0A002); e.push_back(17'h1A004);
      check_got("t2", e);
      check("t2_overrun", 32'(bus.overrun_o), 32'd1);
      check("t2_done", 32'(bus.done_o), 32'd1);
`ifdef HYPERBUS_READ_CAPTURE_STATS_EN
      check("t2_words", 32'(bus.words_o), 32'd3);
`endif

      // 3: ready toggling every edge, no word may be lost.
      do_reset(3);
      edge_cyc(16'hDEAD, 1'b1);
      edge_cyc(16'hC001, 1'b0);
      edge_cyc(16'hC002, 1'b1);
      edge_cyc(16'hC003, 1'b0);
      for (int i = 0; i < 4; i++) edge_cyc(16'h0000, 1'(i % 2 == 0));
      e.delete();
      e.push_back(17'h0C001); e.push_back(17'h0C002); e.push_back(17'h1C003);
      check_got("t3", e);
      check("t3_overrun", 32'(bus.overrun_o), 32'd0);

      // 4: surplus RWDS edges after the burst are ignored.
      do_reset(2);
      edge_cyc(16'hDEAD, 1'b1);
      for (int i = 0; i < 6; i++) edge_cyc(16'hD000 + 16'(i), 1'b1);
      e.delete();
      e.push_back(17'h0D000); e.push_back(17'h1D001);
      check_got("t4", e);
      check("t4_valid", 32'(bus.valid_o), 32'd0);
      check("t4_done", 32'(bus.done_o), 32'd1);

      // 5: reset mid-burst, then a single-word burst.
      do_reset(8);
      edge_cyc(16'hDEAD, 1'b0);
      edge_cyc(16'hB001, 1'b0);
      edge_cyc(16'hB002, 1'b0);
      do_reset(1);
      edge_cyc(16'hDEAD, 1'b1);
      edge_cyc(16'h55AA, 1'b1);
      edge_cyc(16'h0000, 1'b1);
      edge_cyc(16'h0000, 1'b1);
      e.delete();
      e.push_back(17'h155AA);
      check_got("t5", e);

      // 6: empty burst completes on the first edge without producing data.
      do_reset(0);
      for (int i = 0; i < 4; i++) edge_cyc(16'hE000 + 16'(i), 1'b1);
      check("t6_count", 32'(got.size()), 32'd0);
      check("t6_done", 32'(bus.done_o), 32'd1);

      // Random bursts with random data and varying FIFO readiness.
      for (int b = 0; b < 40; b++) begin
         do_reset($urandom_range(0, 10));
         rdy_pct = $urandom_range(20, 100);
         n = SKIP + blen + $urandom_range(0, 4);
         for (int i = 0; i < n; i++) begin
            edge_cyc(16'($urandom), 1'($urandom_range(1, 100) <= rdy_pct));
         end
         for (int i = 0; i < 3; i++) edge_cyc(16'($urandom), 1'b1);
         check("rnd_delivered", 32'(got.size()), 32'(m_acc));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
